// File: rtl/mii_tx_arbiter.sv
// Two-port MII transmit arbiter: PHY reset hold, preamble/SFD, nibble serialisation, IFG.
// Define ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round robin.
module mii_tx_arbiter #(
  parameter int PHY_RST_CYCLES = 250000,
  parameter int IFG_NIBBLES    = 24,
  parameter int MAX_BYTES      = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic [1:0] gnt,
  output logic [1:0] rd,
  output logic       busy,
  output logic       abort,
  output logic       phy_ready,
  output logic       ETH_TX_EN,
  output logic [3:0] ETH_TX_DATA,
  output logic       ETH_RST_N
);
  localparam int PRE_NIBBLES = 16;
  localparam int CNT_A   = (PHY_RST_CYCLES > IFG_NIBBLES) ? PHY_RST_CYCLES : IFG_NIBBLES;
  localparam int CNT_MAX = (CNT_A > PRE_NIBBLES) ? CNT_A : PRE_NIBBLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(MAX_BYTES + 2);

  typedef enum logic [2:0] {
    S_PHY_RST, S_IDLE, S_PRE, S_DLO, S_DHI, S_ABORT, S_IFG
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [3:0]      hi_q, hi_d;
  logic            last_q, last_d;
  logic            sel_q, sel_d;
  logic            phy_ready_q, phy_ready_d;
  logic            tx_en_q, tx_en_d;
  logic [3:0]      tx_data_q, tx_data_d;
  logic            win;
  logic [7:0]      cur_byte;
  logic            cur_last;

  assign cur_byte = sel_q ? data1 : data0;
  assign cur_last = sel_q ? last1 : last0;

`ifdef ARB_FIXED_PRIO_EN
  assign win = ~req[0];
`else
  logic rr_ptr_q, rr_ptr_d;
  // Pointer only matters on a tie; a lone requester always wins.
  assign win = (req == 2'b11) ? rr_ptr_q : req[1];
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_PHY_RST;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      byte_cnt_q  <= '0;
      hi_q        <= '0;
      last_q      <= 1'b0;
      sel_q       <= 1'b0;
      phy_ready_q <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q    <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      hi_q        <= hi_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      phy_ready_q <= phy_ready_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    hi_d        = hi_q;
    last_d      = last_q;
    sel_d       = sel_q;
    phy_ready_d = phy_ready_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      S_PHY_RST: begin
        if (cnt_q == CW'(PHY_RST_CYCLES - 1)) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          phy_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (req != 2'b00) begin
          sel_d   = win;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_d = ~win;
`endif
          cnt_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        byte_cnt_d = '0;
        if (cnt_q == CW'(PRE_NIBBLES - 1)) begin
          cnt_d   = '0;
          state_d = S_DLO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DLO: begin
        hi_d    = cur_byte[7:4];
        last_d  = cur_last;
        state_d = S_DHI;
      end
      S_DHI: begin
        byte_cnt_d = byte_cnt_q + BW'(1);
        cnt_d      = '0;
        if (last_q)                                  state_d = S_IFG;
        else if (byte_cnt_q == BW'(MAX_BYTES - 1))   state_d = S_ABORT;
        else                                         state_d = S_DLO;
      end
      S_ABORT: begin
        cnt_d   = '0;
        state_d = S_IFG;
      end
      S_IFG: begin
        // The IDLE cycle that follows is the last gap nibble, so stop one short.
        if (cnt_q >= CW'(IFG_NIBBLES - 2)) state_d = S_IDLE;
        else                               cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_PHY_RST;
    endcase
  end

  always_comb begin
    gnt       = 2'b00;
    rd        = 2'b00;
    abort     = 1'b0;
    busy      = (state_q != S_IDLE);
    tx_en_d   = 1'b0;
    tx_data_d = 4'h0;
    case (state_q)
      S_PRE: begin
        gnt[sel_q] = 1'b1;
        tx_en_d    = 1'b1;
        tx_data_d  = (cnt_q == CW'(PRE_NIBBLES - 1)) ? 4'hD : 4'h5;
      end
      S_DLO: begin
        gnt[sel_q] = 1'b1;
        tx_en_d    = 1'b1;
        tx_data_d  = cur_byte[3:0];
      end
      S_DHI: begin
        gnt[sel_q] = 1'b1;
        rd[sel_q]  = 1'b1;
        tx_en_d    = 1'b1;
        tx_data_d  = hi_q;
      end
      S_ABORT: begin
        gnt[sel_q] = 1'b1;
        abort      = 1'b1;
      end
      default: ;
    endcase
  end

  assign phy_ready   = phy_ready_q;
  assign ETH_RST_N   = phy_ready_q;
  assign ETH_TX_EN   = tx_en_q;
  assign ETH_TX_DATA = tx_data_q;
endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Scoreboard bench for mii_tx_arbiter: frame-level reference model predicts grant order,
// MII nibble stream, rd/abort counts and inter-frame gaps; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_mii_tx_arbiter;
  localparam int PHY_RST = 16, IFG = 24, MAXB = 64;

  logic       clk = 1'b0, rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] data0 = 8'h0, data1 = 8'h0;
  logic       last0 = 1'b0, last1 = 1'b0;
  logic [1:0] gnt, rd;
  logic       busy, abort, phy_ready, ETH_TX_EN, ETH_RST_N;
  logic [3:0] ETH_TX_DATA;

  always #20 clk = ~clk;

  mii_tx_arbiter #(.PHY_RST_CYCLES(PHY_RST), .IFG_NIBBLES(IFG), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .last0(last0), .last1(last1),
    .gnt(gnt), .rd(rd), .busy(busy), .abort(abort), .phy_ready(phy_ready),
    .ETH_TX_EN(ETH_TX_EN), .ETH_TX_DATA(ETH_TX_DATA), .ETH_RST_N(ETH_RST_N));

  int n_cmp = 0, n_err = 0;
  // request queues ({last, byte}) and staging queues for frames being built
  logic [8:0] q0[$], q1[$], s0[$], s1[$];
  // scoreboard
  int         exp_port[$], exp_len[$], exp_rd[$], exp_gap[$];
  bit         exp_ab[$];
  logic [3:0] exp_nib[$];
  int         rr_m = 0, next_gap = 0;
  bit         mon_en = 1'b1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void build(int p, int len, bit over);
    logic [8:0] e;
    for (int i = 0; i < len; i++) begin
      e = {(!over && i == len - 1), 8'($urandom)};
      if (p == 0) s0.push_back(e); else s1.push_back(e);
    end
  endfunction

  // Frame from staging queue p is the next one on the wire: predict it, then hand it to the requester.
  function automatic void exp_from(int p);
    logic [8:0] s[$];
    int nb;
    bit over;
    if (p == 0) s = s0; else s = s1;
    over = !s[s.size()-1][8];
    nb   = over ? MAXB : s.size();
    for (int i = 0; i < 15; i++) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    for (int i = 0; i < nb; i++) begin
      exp_nib.push_back(s[i][3:0]);
      exp_nib.push_back(s[i][7:4]);
    end
    exp_port.push_back(p);
    exp_len.push_back(16 + 2 * nb);
    exp_rd.push_back(nb);
    exp_ab.push_back(over);
    exp_gap.push_back(next_gap);
    next_gap = over ? 2 : 1;
    rr_m = 1 - p;
    foreach (s[i]) begin
      if (p == 0) q0.push_back(s[i]); else q1.push_back(s[i]);
    end
    if (p == 0) s0.delete(); else s1.delete();
  endfunction

  function automatic void issue(logic [1:0] mask);
    int first;
`ifdef ARB_FIXED_PRIO_EN
    first = mask[0] ? 0 : 1;
`else
    first = (mask == 2'b11) ? rr_m : (mask[1] ? 1 : 0);
`endif
    exp_from(first);
    if (mask == 2'b11) exp_from(1 - first);
  endfunction

  // ---------------- requester driver ----------------
  logic [1:0] drv_rd, drv_gnt;
  logic       drv_ab;
  initial begin
    forever begin
      @(negedge clk);
      drv_rd = rd; drv_gnt = gnt; drv_ab = abort;
      @(posedge clk); #1;
      if (drv_rd[0] && q0.size() > 0) void'(q0.pop_front());
      if (drv_rd[1] && q1.size() > 0) void'(q1.pop_front());
      if (drv_ab && drv_gnt[0]) q0.delete();
      if (drv_ab && drv_gnt[1]) q1.delete();
      req[0] = (q0.size() > 0);
      req[1] = (q1.size() > 0);
      data0  = req[0] ? q0[0][7:0] : 8'h0;
      last0  = req[0] ? q0[0][8]   : 1'b0;
      data1  = req[1] ? q1[0][7:0] : 8'h0;
      last1  = req[1] ? q1[0][8]   : 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic [3:0] got[$];
  bit         in_frame = 1'b0;
  int         gap = 0, rdc0 = 0, rdc1 = 0, abc = 0, stray = 0, fr_gap = 0;
  logic [1:0] fr_gnt;

  task automatic end_frame();
    int p, n, nr, g, bad;
    bit ab;
    logic [3:0] e, bad_got, bad_exp;
    if (exp_port.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_frame: got %0d nibbles want no frame", got.size());
      return;
    end
    p = exp_port.pop_front(); n = exp_len.pop_front(); nr = exp_rd.pop_front();
    g = exp_gap.pop_front();  ab = exp_ab.pop_front();
    chk("frame_gnt", fr_gnt, 32'(1 << p));
    chk("frame_tx_en_len", got.size(), n);
    bad = -1; bad_got = 4'h0; bad_exp = 4'h0;
    for (int i = 0; i < n; i++) begin
      e = exp_nib.pop_front();
      if (bad < 0 && (i >= got.size() || got[i] !== e)) begin
        bad = i; bad_exp = e; bad_got = (i < got.size()) ? got[i] : 4'hx;
      end
    end
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL frame_nibbles: port %0d nibble %0d got %h want %h", p, bad, bad_got, bad_exp);
    end
    chk("frame_rd_granted", (p == 0) ? rdc0 : rdc1, nr);
    chk("frame_rd_other", (p == 0) ? rdc1 : rdc0, 0);
    chk("frame_abort", abc, ab);
    if (g == 1)      chk("ifg_exact", fr_gap, IFG);
    else if (g == 2) chk("ifg_min", fr_gap >= IFG, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_frame = 1'b0;
      end else begin
        if (ETH_TX_EN === 1'b1) begin
          if (!in_frame) begin
            in_frame = 1'b1; got.delete();
            rdc0 = 0; rdc1 = 0; abc = 0; fr_gnt = gnt; fr_gap = gap;
          end
          got.push_back(ETH_TX_DATA);
        end else begin
          if (in_frame) begin
            in_frame = 1'b0; end_frame(); gap = 0;
          end
          gap++;
        end
        if (in_frame) begin
          rdc0 += int'(rd[0]); rdc1 += int'(rd[1]); abc += int'(abort);
        end else if (rd != 2'b00 || abort) begin
          stray++;
        end
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; q0.delete(); q1.delete();
    repeat (3) @(negedge clk);
    chk("reset_state", {ETH_RST_N, phy_ready, gnt, rd, busy, abort, ETH_TX_EN, ETH_TX_DATA},
        {1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'h0});
    rst = 1'b1; rr_m = 0; next_gap = 0;
  endtask

  task automatic wait_phy();
    int lows = 0, early = 0;
    for (int i = 0; i < 200 && ETH_RST_N === 1'b0; i++) begin
      if (gnt !== 2'b00) early++;
      lows++;
      @(negedge clk);
    end
    chk("phy_hold_len", lows, PHY_RST);
    chk("phy_ready_up", {ETH_RST_N, phy_ready}, 2'b11);
    chk("gnt_during_hold", early, 0);
  endtask

  task automatic wait_drain(string nm);
    int i = 0;
    while ((q0.size() > 0 || q1.size() > 0) && i < 3000) begin
      @(posedge clk); #2; i++;
    end
    chk({"drain_timeout_", nm}, i < 3000, 1);
  endtask

  task automatic wait_idle(string nm);
    int i = 0;
    @(negedge clk);
    while (busy !== 1'b0 && i < 3000) begin
      @(negedge clk); i++;
    end
    chk({"idle_timeout_", nm}, i < 3000, 1);
    next_gap = 2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [1:0] mask;
    bit over;

    // Reset sequence with a port 0 request already pending during the PHY hold
    do_reset();
    s0 = '{9'h012, 9'h034, 9'h056, 9'h178};
    exp_from(0);
    wait_phy();
    wait_drain("t1");
    wait_idle("t1");

    // Simultaneous requests from reset, then a repeat
    do_reset();
    wait_phy();
    build(0, 2, 1'b0); build(1, 2, 1'b0); issue(2'b11);
    wait_drain("t2a");
    build(0, 2, 1'b0); build(1, 2, 1'b0); issue(2'b11);
    wait_drain("t2b");
    wait_idle("t2");

    // Oversize frame on port 1, then a normal port 0 frame
    build(1, 68, 1'b1); issue(2'b10);
    wait_drain("t3a");
    wait_idle("t3a");
    chk("gnt_after_ifg", gnt, 2'b00);
    build(0, 3, 1'b0); issue(2'b01);
    wait_drain("t3b");
    wait_idle("t3b");

    // Back-to-back frames with port 0 req held throughout
    build(0, 5, 1'b0); exp_from(0);
    build(0, 4, 1'b0); exp_from(0);
    wait_drain("t4");

    // Randomised rounds, each issued while the previous frame's IFG runs
    for (int r = 0; r < 40; r++) begin
      mask = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          over = ($urandom_range(0, 7) == 0);
          build(p, over ? $urandom_range(65, 70) : $urandom_range(1, 9), over);
        end
      end
      issue(mask);
      wait_drain("rand");
    end
    wait_idle("rand");
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_port.size(), 0);
    chk("stray_strobes", stray, 0);

    // Reset during byte 3 of a port 0 frame
    mon_en = 1'b0;
    build(0, 6, 1'b0);
    foreach (s0[i]) q0.push_back(s0[i]);
    s0.delete();
    cnt = 0;
    for (int i = 0; i < 400 && cnt < 2; i++) begin
      @(negedge clk);
      if (rd[0]) cnt++;
    end
    chk("midrst_reach_byte3", cnt, 2);
    @(negedge clk);
    rst = 1'b0; q0.delete();
    @(negedge clk);
    chk("midrst_outputs", {ETH_TX_EN, gnt, rd, abort, ETH_RST_N, phy_ready}, 8'h00);
    rst = 1'b1;
    wait_phy();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
